// File: rtl/debug_probe_display.sv
// Board-level probe viewer: selects, snapshots and pages a probe channel onto a 4-digit 7-seg display and a LED bank.
// Latency: snapshot 1 cycle after sel/probe; display/LED outputs registered 1 cycle after page/digit state.
// Backpressure: none; free-running scan, sel/freeze/auto_mode are levels, page_step is a single-cycle pulse.
module debug_probe_display #(
    parameter int NCH         = 12,
    parameter int W           = 32,
    parameter int REFRESH_CYC = 100000,
    parameter int SCROLL_CYC  = 100000000,
    localparam int SELW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [NCH*W-1:0] probe_bus,
    input  logic [SELW-1:0]  sel,
    input  logic             freeze,
    input  logic             auto_mode,
    input  logic             page_step,
    output logic [6:0]       seg,
    output logic [3:0]       anode,
    output logic             dp,
    output logic [15:0]      led
);
    localparam int NPAGE = (W + 15) / 16;
    localparam int PW    = (NPAGE > 1) ? $clog2(NPAGE) : 1;
    localparam int RW    = $clog2(REFRESH_CYC);
    localparam int SW    = $clog2(SCROLL_CYC);

    logic [W-1:0]          snap;
    logic [W-1:0]          ch_sel;
    logic [16*NPAGE-1:0]   snap_pad;
    logic [15:0]           win;
    logic [3:0]            nib;
    logic [SELW-1:0]       sel_q;
    logic                  frz_q;
    logic [PW-1:0]         page;
    logic [PW-1:0]         page_nxt;
    logic [SW-1:0]         scroll_cnt;
    logic [RW-1:0]         refresh_cnt;
    logic [1:0]            digit;
    logic                  sel_chg;
    logic                  scroll_end;
    logic                  refresh_end;

    // Unmatched select values (sel >= NCH) fall through to the all-ones default.
    always_comb begin
        ch_sel = '1;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) ch_sel = probe_bus[k*W +: W];
        end
    end

    always_comb begin
        snap_pad        = '0;
        snap_pad[W-1:0] = snap;
        win             = '0;
        for (int p = 0; p < NPAGE; p++) begin
            if (page == PW'(p)) win = snap_pad[p*16 +: 16];
        end
    end

    assign nib         = win[{digit, 2'b00} +: 4];
    assign sel_chg     = (sel != sel_q);
    assign scroll_end  = (scroll_cnt == SW'(SCROLL_CYC - 1));
    assign refresh_end = (refresh_cnt == RW'(REFRESH_CYC - 1));
    assign page_nxt    = (page == PW'(NPAGE - 1)) ? '0 : page + PW'(1);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snap  <= '0;
            sel_q <= '0;
            frz_q <= 1'b0;
        end else begin
            sel_q <= sel;
            frz_q <= freeze;
            if (!freeze) snap <= ch_sel;
        end
    end

    // A select change restarts paging and takes priority over step and scroll expiry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            page       <= '0;
            scroll_cnt <= '0;
        end else begin
            if (sel_chg) begin
                page <= '0;
            end else if (auto_mode) begin
                if (scroll_end) page <= page_nxt;
            end else if (page_step) begin
                page <= page_nxt;
            end

            if (!auto_mode || sel_chg || scroll_end) scroll_cnt <= '0;
            else                                     scroll_cnt <= scroll_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            refresh_cnt <= '0;
            digit       <= 2'd0;
        end else begin
            if (refresh_end) begin
                refresh_cnt <= '0;
                digit       <= digit + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            anode <= 4'b1110;
            seg   <= 7'b1000000;
            dp    <= 1'b1;
            led   <= 16'h0000;
        end else begin
            anode <= ~(4'b0001 << digit);
            seg   <= hex7(nib);
            dp    <= ~(frz_q && (digit == 2'd3));
            led   <= {8'(sel), 4'(page), freeze, auto_mode, 2'b00};
        end
    end
endmodule

// File: tb/tb_debug_probe_display.sv
// Bench for debug_probe_display: directed scenarios plus random traffic against a cycle-level reference model.
module tb_debug_probe_display;
    localparam int RC    = 4;
    localparam int SC    = 10;
    localparam int NPG   = 3;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [47:0]  ch [4];
    logic [191:0] probe_bus;
    logic [143:0] probe_bus2;
    logic [1:0]   sel = 2'd0;
    logic         freeze = 1'b0;
    logic         auto_mode = 1'b0;
    logic         page_step = 1'b0;
    logic [6:0]   seg, seg2;
    logic [3:0]   anode, anode2;
    logic         dp, dp2;
    logic [15:0]  led, led2;

    int n_chk = 0;
    int n_fail = 0;

    logic [47:0] m_snap;
    int          m_page, m_scroll, m_ref, m_digit, m_selq;
    bit          m_frz;
    bit          oor_en = 1'b0;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    assign probe_bus  = {ch[3], ch[2], ch[1], ch[0]};
    assign probe_bus2 = {ch[2], ch[1], ch[0]};

    debug_probe_display #(.NCH(4), .W(48), .REFRESH_CYC(RC), .SCROLL_CYC(SC)) dut (
        .clk(clk), .resetn(resetn), .probe_bus(probe_bus), .sel(sel), .freeze(freeze),
        .auto_mode(auto_mode), .page_step(page_step), .seg(seg), .anode(anode), .dp(dp), .led(led)
    );

    debug_probe_display #(.NCH(3), .W(48), .REFRESH_CYC(RC), .SCROLL_CYC(SC)) dut_oor (
        .clk(clk), .resetn(resetn), .probe_bus(probe_bus2), .sel(sel), .freeze(freeze),
        .auto_mode(auto_mode), .page_step(page_step), .seg(seg2), .anode(anode2), .dp(dp2), .led(led2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_snap = '0; m_page = 0; m_scroll = 0; m_ref = 0; m_digit = 0; m_selq = 0; m_frz = 1'b0;
    endtask

    // One clock: predict what the registers load at this edge, then compare just after it.
    task automatic tick();
        logic [63:0] t;
        logic [15:0] w;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [15:0] e_led;
        logic [47:0] n_snap;
        int          n_page, n_scroll, n_ref, n_digit;
        bit          chg;
        if (!resetn) begin
            e_an = 4'b1110; e_seg = 7'b1000000; e_dp = 1'b1; e_led = 16'h0;
            model_reset();
            n_snap = '0; n_page = 0; n_scroll = 0; n_ref = 0; n_digit = 0;
        end else begin
            t     = {16'h0, m_snap} >> (16 * m_page);
            w     = t[15:0];
            e_an  = ~(4'b0001 << m_digit);
            e_seg = glyph[(w >> (4 * m_digit)) & 16'hF];
            e_dp  = !(m_frz && m_digit == 3);
            e_led = {8'(sel), 4'(m_page), freeze, auto_mode, 2'b00};
            chg      = (int'(sel) != m_selq);
            n_snap   = freeze ? m_snap : ch[sel];
            if (chg)            n_page = 0;
            else if (auto_mode) n_page = (m_scroll == SC - 1) ? (m_page + 1) % NPG : m_page;
            else if (page_step) n_page = (m_page + 1) % NPG;
            else                n_page = m_page;
            n_scroll = (!auto_mode || chg) ? 0 : (m_scroll + 1) % SC;
            n_ref    = (m_ref + 1) % RC;
            n_digit  = (m_ref == RC - 1) ? (m_digit + 1) % 4 : m_digit;
            m_selq   = int'(sel);
            m_frz    = freeze;
        end
        @(posedge clk);
        #1;
        m_snap = n_snap; m_page = n_page; m_scroll = n_scroll; m_ref = n_ref; m_digit = n_digit;
        check("anode", {12'h0, anode}, {12'h0, e_an});
        check("seg", {9'h0, seg}, {9'h0, e_seg});
        check("dp", {15'h0, dp}, {15'h0, e_dp});
        check("led", led, e_led);
        if (oor_en) check("oor_seg", {9'h0, seg2}, {9'h0, glyph[15]});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset_check();
        resetn = 1'b0;
        #1;
        check("rst_anode", {12'h0, anode}, 16'h000E);
        check("rst_seg", {9'h0, seg}, 16'h0040);
        check("rst_dp", {15'h0, dp}, 16'h0001);
        check("rst_led", led, 16'h0000);
        model_reset();
    endtask

    initial begin
        int guard;
        int exp_pg [3];
        exp_pg[0] = 1; exp_pg[1] = 2; exp_pg[2] = 0;
        ch[0] = 48'h0123_4567_89AB;
        ch[1] = 48'hCDEF_0011_2233;
        ch[2] = 48'h0000_BEEF_1234;
        ch[3] = 48'h5566_7788_99AA;
        model_reset();

        // Reset state, then scan channel 2.
        ticks(3);
        resetn = 1'b1;
        sel = 2'd2;
        ticks(22);

        // Reset asserted mid-scan with no clock edge.
        async_reset_check();
        ticks(2);
        resetn = 1'b1;
        ticks(20);

        // Manual paging: BEEF, 0000, wrap to 1234.
        for (int k = 0; k < 3; k++) begin
            page_step = 1'b1;
            tick();
            page_step = 1'b0;
            tick();
            check("led_page", {12'h0, led[7:4]}, 16'(exp_pg[k]));
            ticks(16);
        end

        // Freeze, then disturb channel 2 and the select.
        freeze = 1'b1;
        tick();
        ch[2] = 48'h0;
        sel = 2'd3;
        ticks(2);
        check("led_frozen", {15'h0, led[3]}, 16'h0001);
        check("led_page_sel", {12'h0, led[7:4]}, 16'h0000);
        ticks(20);
        freeze = 1'b0;
        ticks(4);

        // Auto-scroll with ignored page_step pulses.
        auto_mode = 1'b1;
        for (int i = 0; i < 45; i++) begin
            page_step = ($urandom_range(0, 3) == 0);
            tick();
        end
        page_step = 1'b0;
        guard = 0;
        while (m_scroll != SC - 1 && guard < 30) begin
            tick();
            guard++;
        end
        check("scroll_sync", 16'(guard < 30), 16'h0001);
        sel = sel + 2'd1;
        tick();
        tick();
        check("sel_over_scroll", {12'h0, led[7:4]}, 16'h0000);
        ticks(12);

        // Out-of-range select on the NCH=3 build reads all-ones on every page.
        auto_mode = 1'b0;
        sel = 2'd3;
        ticks(2);
        oor_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ticks(16);
            page_step = 1'b1;
            tick();
            page_step = 1'b0;
        end
        ticks(16);
        oor_en = 1'b0;

        // Random traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                async_reset_check();
                ticks(2);
                resetn = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) ch[$urandom_range(0, 3)] = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            if ($urandom_range(0, 7) == 0)  sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) freeze = ~freeze;
            if ($urandom_range(0, 29) == 0) auto_mode = ~auto_mode;
            page_step = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
